// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO that feeds a UART transmitter over tx_val/tx_data/tx_busy.
// Define UART_TX_FIFO_OVF_EN to add the sticky overflow flag (ovf_o) and its clear (ovf_clr_i).
module uart_tx_fifo #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [7:0]    wr_data_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    input  logic          tx_busy_i,
    output logic          tx_val_o,
    output logic [7:0]    tx_data_o
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic          ovf_o,
    input  logic          ovf_clr_i
`endif
);

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_BUSY = 2'd2
    } state_t;

    state_t        state_q;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          tx_val_q;
    logic [7:0]    tx_data_q;
    logic          push_c;
    logic          pop_c;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign tx_val_o  = tx_val_q;
    assign tx_data_o = tx_data_q;

    // full comes from the registered count, so a same-cycle pop never frees a slot for the write
    assign push_c = wr_en_i && !full_o;
    assign pop_c  = (state_q == F_REQ) && tx_busy_i;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Byte storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Feeder: present head byte, pop when the transmitter raises busy, wait for busy to fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= F_IDLE;
            tx_val_q  <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            case (state_q)
                F_IDLE: begin
                    if (!empty_o && !tx_busy_i) begin
                        tx_data_q <= mem_q[rd_ptr_q];
                        tx_val_q  <= 1'b1;
                        state_q   <= F_REQ;
                    end
                end
                F_REQ: begin
                    if (tx_busy_i) begin
                        tx_val_q <= 1'b0;
                        state_q  <= F_BUSY;
                    end
                end
                F_BUSY: begin
                    if (!tx_busy_i) begin
                        state_q <= F_IDLE;
                    end
                end
                default: begin
                    tx_val_q <= 1'b0;
                    state_q  <= F_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q;

    // Sticky overflow; a new overflow wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (wr_en_i && full_o) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and feeder that sits directly upstream of the UART transmitter. It accepts bytes from a producer (CPU/register interface or packetiser) at full clock rate and stores them in a circular FIFO. It presents them one at a time to the transmitter through its tx_val/tx_data/busy handshake. This lets the producer burst several bytes without polling the transmitter's busy flag.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256.
- AW, log2(DEPTH): pointer width; derived, not overridden.
- clk  in  1  system clock, same domain as transmitter.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  producer write strobe, one byte per cycle.
- wr_data  in  8  producer byte.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  AW+1  bytes stored, excluding the byte already accepted by the transmitter.
- tx_busy  in  1  transmitter busy flag.
- tx_val  out  1  byte-valid request to transmitter.
- tx_data  out  8  byte presented to transmitter.
- ovf  out  1  sticky overflow flag; present only with UART_TX_FIFO_OVF_EN.
- ovf_clr  in  1  clears ovf; present only with UART_TX_FIFO_OVF_EN.

## Operation
- Storage: DEPTH x 8 register array, no reset. Write pointer wr_ptr and read pointer rd_ptr are AW bits wide and wrap modulo DEPTH. The count register is AW+1 bits wide.
- Write: a write is accepted when wr_en=1 and full=0. The byte goes to mem[wr_ptr] and wr_ptr increments.
- Write while full: the byte is dropped, with no pointer or count change. full is evaluated from the registered count, so a same-cycle pop does not make room.
- Feeder FSM states:
  - F_IDLE: if empty=0 and tx_busy=0, load tx_data<=mem[rd_ptr], set tx_val<=1, and go to F_REQ.
  - F_REQ: hold tx_val and tx_data. When tx_busy=1, set tx_val<=0, increment rd_ptr (pop), and go to F_BUSY. If tx_busy never rises, the FSM stays in F_REQ indefinitely.
  - F_BUSY: when tx_busy=0, go to F_IDLE.
- Pop and accepted write in the same cycle: count is unchanged and both pointers advance.
- tx_val is never asserted while tx_busy=1 at F_IDLE. Exactly one pop occurs per tx_val assertion, so no byte is duplicated or skipped.
- All outputs are registered except full, empty and count, which are combinational decodes of the count register.

## Timing
- Reset values: tx_val=0, tx_data=8'h00, state=F_IDLE, wr_ptr=0, rd_ptr=0, count=0 (so empty=1, full=0), ovf=0.
- Reset mid-transfer: all queued bytes are discarded. The transmitter shares rst, so both sides restart idle.
- Write-to-request latency: wr_en sampled at edge N into an empty FIFO with tx_busy=0 gives count=1 after N and tx_val=1 after edge N+1.
- Request-to-accept: the transmitter raises busy 2 cycles after it samples tx_val. tx_val therefore stays high for 2 cycles, and the pop happens at the edge where tx_busy=1 is first seen.
- Between bytes: after tx_busy falls, the next tx_val rises 2 edges later (F_BUSY->F_IDLE, then F_IDLE->F_REQ).
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.

## Configuration
- UART_TX_FIFO_OVF_EN defined:
  - ovf and ovf_clr ports exist.
  - ovf is set on the edge after any write attempted while full, and stays set until ovf_clr=1.
  - If ovf_clr=1 and an overflowing write occur in the same cycle, set wins.
- UART_TX_FIFO_OVF_EN undefined: neither port exists, and dropped writes are silent.

## Test plan
- Single byte: write 8'hA5 after reset with tx_busy=0. Expect tx_val=1 and tx_data=8'hA5 one cycle after count=1. Model busy rising 2 cycles later; expect tx_val=0, count=0 and empty=1.
- Burst of 4 (8'h01..8'h04) with a real transmitter model: the serial output carries 01,02,03,04 in order. Expect exactly 4 tx_val assertions and no assertion while tx_busy=1.
- Fill and overflow: write 17 bytes (DEPTH=16) with tx_busy held 1. Expect full=1 and count=16, with the 17th byte dropped. With the macro defined, expect ovf=1 until ovf_clr.
- Simultaneous write and pop at count=16: the write is dropped and count becomes 15. At count=5, write plus pop leaves count=5.
- Wrap-around: push and drain 40 bytes in interleaved bursts. Expect the data sequence to be preserved across the pointer wrap.
- Reset mid-transfer: assert rst while in F_REQ with 3 bytes queued. Expect tx_val=0, count=0, empty=1 immediately; no stale byte is sent after release.
